// File: rtl/flag_pkg.sv
// Shared types for the status-flag controller and the branch unit:
// flag bit positions, the packed flag word and the condition-code encoding.
package flag_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  // Bit 3 down to bit 0: sign, overflow, carry, zero.
  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } flags_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  // Replace only the flags selected by mask with the ALU result.
  function automatic flags_t alu_merge(input flags_t cur,
                                       input logic [FLAG_W-1:0] val,
                                       input logic [FLAG_W-1:0] mask);
    logic [FLAG_W-1:0] cur_v;
    cur_v = cur;
    return flags_t'((cur_v & ~mask) | (val & mask));
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator; shared between the flag
// controller and the branch unit.
module cond_eval
  import flag_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_cond_true
);

  logic [FLAG_W-1:0] w_f;
  logic              w_z;
  logic              w_c;
  logic              w_v;
  logic              w_n;

  assign w_f = i_flags;
  assign w_z = w_f[FLAG_Z];
  assign w_c = w_f[FLAG_C];
  assign w_v = w_f[FLAG_V];
  assign w_n = w_f[FLAG_N];

  always_comb begin
    o_cond_true = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_true = w_z;
      COND_NE: o_cond_true = ~w_z;
      COND_CS: o_cond_true = w_c;
      COND_CC: o_cond_true = ~w_c;
      COND_MI: o_cond_true = w_n;
      COND_PL: o_cond_true = ~w_n;
      COND_VS: o_cond_true = w_v;
      COND_VC: o_cond_true = ~w_v;
      COND_HI: o_cond_true = w_c & ~w_z;
      COND_LS: o_cond_true = ~w_c | w_z;
      COND_GE: o_cond_true = (w_n == w_v);
      COND_LT: o_cond_true = (w_n != w_v);
      COND_GT: o_cond_true = ~w_z & (w_n == w_v);
      COND_LE: o_cond_true = w_z | (w_n != w_v);
      COND_AL: o_cond_true = 1'b1;
      COND_NV: o_cond_true = 1'b0;
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Architectural Z/C/V/N flag owner: arbitrates ALU, direct and stack writes,
// keeps the interrupt flag stack, and evaluates the current condition code.
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [FLAG_W-1:0]          alu_flags,
  input  logic [FLAG_W-1:0]          alu_mask,
  input  logic                       wr_en,
  input  logic [FLAG_W-1:0]          wr_data,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  input  logic [3:0]                 cond,
  output logic [FLAG_W-1:0]          flags,
  output logic                       cond_true,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t           r_flags;
  flags_t           r_stack [DEPTH];
  logic [CNT_W-1:0] r_depth;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;
  flags_t           w_top;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_swap;
  logic             w_err_set;
  flags_t           w_flags_nxt;

  assign w_full     = (r_depth == CNT_W'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_top_idx  = IDX_W'(r_depth - CNT_W'(1));
  assign w_push_idx = IDX_W'(r_depth);
  assign w_top      = r_stack[w_top_idx];

  // A lone push/pop acts only when there is room/data; push+pop swaps with the top.
  assign w_push_ok = push & ~pop & ~w_full;
  assign w_pop_ok  = pop & ~push & ~w_empty;
  assign w_swap    = push & pop & ~w_empty;
  assign w_err_set = (push & ~pop & w_full) | (pop & w_empty);

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_pop_ok || w_swap) begin
      w_flags_nxt = w_top;
    end else if (wr_en) begin
      w_flags_nxt = flags_t'(wr_data);
    end else if (alu_valid) begin
      w_flags_nxt = alu_merge(r_flags, alu_flags, alu_mask);
    end
  end

  // Stack entries always capture the flags as they were before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
      r_stack <= '{default: '0};
    end else begin
      r_flags <= w_flags_nxt;
      if (w_push_ok) begin
        r_stack[w_push_idx] <= r_flags;
        r_depth             <= r_depth + CNT_W'(1);
      end else if (w_pop_ok) begin
        r_depth <= r_depth - CNT_W'(1);
      end else if (w_swap) begin
        r_stack[w_top_idx] <= r_flags;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  cond_eval u_cond_eval (
    .i_cond      (cond_e'(cond)),
    .i_flags     (r_flags),
    .o_cond_true (cond_true)
  );

  assign flags = r_flags;
  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_flag_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alu_valid = 1'b0;
  logic [3:0] alu_flags = '0;
  logic [3:0] alu_mask = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] cond = '0;
  logic [3:0] flags;
  logic       cond_true;
  logic [2:0] depth;
  logic       full;
  logic       empty;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_flags = '0;
  logic [3:0] m_stack[$];
  logic       m_err = 1'b0;

  flag_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_flags (alu_flags),
    .alu_mask  (alu_mask),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Even codes test a base predicate, odd codes its negation.
  function automatic logic mcond(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, v, n;
    logic [7:0] base;
    z = f[0]; cy = f[1]; v = f[2]; n = f[3];
    base = {1'b1, ~z & (n == v), (n == v), cy & ~z, v, n, cy, z};
    return base[c[3:1]] ^ c[0];
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [3:0] pre;
    int         n;
    logic       bad;
    if (reset) begin
      m_flags = '0;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      pre = m_flags;
      n   = m_stack.size();
      bad = 1'b0;
      if (push && pop && n > 0) begin
        m_flags = m_stack[n-1];
        m_stack[n-1] = pre;
      end else if (pop && !push && n > 0) begin
        m_flags = m_stack.pop_back();
      end else begin
        if (pop) bad = 1'b1;
        if (push && !pop) begin
          if (n < DEPTH) m_stack.push_back(pre);
          else bad = 1'b1;
        end
        if (wr_en) m_flags = wr_data;
        else if (alu_valid) m_flags = (m_flags & ~alu_mask) | (alu_flags & alu_mask);
      end
      if (bad) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_flags", 8'(flags), 8'(m_flags));
    chk("m_depth", 8'(depth), 8'(m_stack.size()));
    chk("m_full", 8'(full), 8'(m_stack.size() == DEPTH));
    chk("m_empty", 8'(empty), 8'(m_stack.size() == 0));
    chk("m_err", 8'(err), 8'(m_err));
    chk("m_cond", 8'(cond_true), 8'(mcond(cond, m_flags)));
  end

  task automatic idle();
    alu_valid = 1'b0; alu_flags = '0; alu_mask = '0;
    wr_en = 1'b0; wr_data = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_alu(input logic [3:0] f, input logic [3:0] m);
    alu_valid = 1'b1; alu_flags = f; alu_mask = m; step();
  endtask

  task automatic do_wr(input logic [3:0] d);
    wr_en = 1'b1; wr_data = d; step();
  endtask

  task automatic do_push_wr(input logic [3:0] d);
    push = 1'b1; wr_en = 1'b1; wr_data = d; step();
  endtask

  task automatic do_pop();
    pop = 1'b1; step();
  endtask

  logic [3:0] fvals [7];
  logic [3:0] exp_pop [4];

  initial begin
    fvals   = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1010};
    exp_pop = '{4'b0100, 4'b0011, 4'b0010, 4'b0001};
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_flags", 8'(flags), 8'h0);
    chk("rst_depth", 8'(depth), 8'h0);
    chk("rst_empty", 8'(empty), 8'h1);
    chk("rst_full", 8'(full), 8'h0);
    chk("rst_err", 8'(err), 8'h0);
    chk("rst_cond_eq", 8'(cond_true), 8'h0);

    do_alu(4'b1111, 4'b0101);
    chk("alu_mask1", 8'(flags), 8'h5);
    do_alu(4'b0000, 4'b0001);
    chk("alu_mask2", 8'(flags), 8'h4);

    wr_en = 1'b1; wr_data = 4'b1010;
    alu_valid = 1'b1; alu_flags = 4'b0101; alu_mask = 4'hF;
    step();
    chk("wr_over_alu", 8'(flags), 8'hA);

    do_wr(4'b0001);
    do_push_wr(4'b0010);
    do_push_wr(4'b0011);
    do_push_wr(4'b0100);
    do_push_wr(4'b0101);
    chk("fill_full", 8'(full), 8'h1);
    chk("fill_depth", 8'(depth), 8'h4);
    do_push_wr(4'b0110);
    chk("ovf_err", 8'(err), 8'h1);
    chk("ovf_depth", 8'(depth), 8'h4);
    chk("ovf_flags", 8'(flags), 8'h6);

    for (int i = 0; i < 4; i++) begin
      do_pop();
      chk("drain_flags", 8'(flags), 8'(exp_pop[i]));
    end
    chk("drain_empty", 8'(empty), 8'h1);
    do_pop();
    chk("udf_flags", 8'(flags), 8'h1);
    chk("udf_err", 8'(err), 8'h1);
    err_clr = 1'b1; step();
    chk("err_clr", 8'(err), 8'h0);

    pop = 1'b1; err_clr = 1'b1; step();
    chk("err_set_wins", 8'(err), 8'h1);
    err_clr = 1'b1; step();

    push = 1'b1; pop = 1'b1; wr_en = 1'b1; wr_data = 4'b1001; step();
    chk("pp0_err", 8'(err), 8'h1);
    chk("pp0_depth", 8'(depth), 8'h0);
    chk("pp0_flags", 8'(flags), 8'h9);
    err_clr = 1'b1; step();

    do_wr(4'b0011);
    do_push_wr(4'b1100);
    push = 1'b1; pop = 1'b1; wr_en = 1'b1; wr_data = 4'b1111; step();
    chk("swap_flags", 8'(flags), 8'h3);
    chk("swap_depth", 8'(depth), 8'h1);
    chk("swap_err", 8'(err), 8'h0);
    do_pop();
    chk("swap_top", 8'(flags), 8'hC);

    for (int k = 0; k < 7; k++) begin
      do_wr(fvals[k]);
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        step();
        chk("cond_sweep", 8'(cond_true), 8'(mcond(cond, fvals[k])));
        if (fvals[k] == 4'b1000) begin
          if (c == 10) chk("ge_1000", 8'(cond_true), 8'h0);
          if (c == 11) chk("lt_1000", 8'(cond_true), 8'h1);
          if (c == 12) chk("gt_1000", 8'(cond_true), 8'h0);
          if (c == 13) chk("le_1000", 8'(cond_true), 8'h1);
        end
        if (fvals[k] == 4'b0000 && c == 8) chk("hi_0000", 8'(cond_true), 8'h0);
        if (fvals[k] == 4'b0010 && c == 8) chk("hi_0010", 8'(cond_true), 8'h1);
      end
    end
    cond = 4'd0;

    do_wr(4'b1111);
    push = 1'b1; step();
    push = 1'b1; step();
    chk("pre_rst_depth", 8'(depth), 8'h2);
    chk("pre_rst_flags", 8'(flags), 8'hF);
    #2 reset = 1'b1;
    #1;
    chk("async_flags", 8'(flags), 8'h0);
    chk("async_depth", 8'(depth), 8'h0);
    chk("async_empty", 8'(empty), 8'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    do_pop();
    chk("post_rst_err", 8'(err), 8'h1);
    chk("post_rst_flags", 8'(flags), 8'h0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Status-flag controller for the processor datapath: owns the architectural zero/carry/overflow/sign flags and sequences every write to them. Writes come from the ALU (masked per flag), from a direct move-to-status write, and from a small LIFO flag stack used on interrupt entry and return. It also evaluates a 4-bit condition code against the registered flags for branch and conditional-execute decisions.

## Interface
- DEPTH, 4, number of flag-stack entries (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result flags valid this cycle
- alu_flags  input  4  {sign, overflow, carry, zero} from ALU
- alu_mask  input  4  per-flag update enable for alu_flags, same bit order
- wr_en  input  1  direct write of all four flags
- wr_data  input  4  value for direct write
- push  input  1  save current flags to stack (interrupt entry)
- pop  input  1  restore flags from stack top (interrupt return)
- err_clr  input  1  clear sticky error
- cond  input  4  condition code to evaluate
- flags  output  4  registered flags; [0]=zero, [1]=carry, [2]=overflow, [3]=sign
- cond_true  output  1  cond evaluated against `flags`
- depth  output  $clog2(DEPTH+1)  occupied stack entries
- full  output  1  depth == DEPTH
- empty  output  1  depth == 0
- err  output  1  sticky push-on-full / pop-on-empty indicator

## Operation
- Flag write priority per cycle: valid pop > wr_en > alu_valid.
  - pop: flags <= stack top.
  - wr_en: flags <= wr_data.
  - alu_valid: flags[i] <= alu_flags[i] where alu_mask[i]=1; otherwise hold.
- push writes the pre-edge flags value (before any same-cycle update) to stack[depth]; depth+1.
- push and pop in the same cycle with depth ≥1: swap. stack top <= pre-edge flags; flags <= old top; depth unchanged; wr_en and alu_valid ignored.
- push+pop with depth 0: pop is invalid. Set err; no stack change; flags follow wr_en/alu path.
- push when full (without pop): ignored, err set, depth unchanged; flag writes still apply.
- pop when empty (without push): ignored, err set; flag writes follow wr_en/alu path.
- err: set by any ignored push/pop; cleared by err_clr. A set on the same cycle wins over the clear.
- Condition codes (N=sign, V=overflow, C=carry, Z=zero):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0

## Timing
- Reset (asynchronous, immediate): flags=0, depth=0, err=0, stack contents=0. Outputs: empty=1, full=0, cond_true=value for flags=0.
- All flag, stack, depth and err updates take effect on the rising clk edge. Latency is 1 cycle from the input to `flags`.
- cond_true is combinational from `cond` and registered `flags`. New flags become visible to cond_true in the cycle after the write.
- full and empty decode combinationally from the registered depth.
- Reset mid-sequence discards all stack contents. No handshake; every input is sampled each cycle.

## Structure
- Package flag_pkg:
  - flag index constants FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3
  - flags_t (4-bit packed struct/vector)
  - cond_e enum for the 16 condition codes
- Sub-module cond_eval: combinational, inputs cond_e and flags_t, output cond_true. It is reused by the branch unit.
- Stack: register array of DEPTH × flags_t plus a depth counter. No separate sub-module.

## Test plan
- Masked ALU update: reset, then alu_valid=1, alu_flags=4'b1111, alu_mask=4'b0101 -> flags=4'b0101 next cycle. Repeat with alu_flags=0, mask=4'b0001 -> flags=4'b0100.
- Priority: wr_en=1, wr_data=4'b1010 and alu_valid=1, alu_flags=4'b0101, mask=4'hF in the same cycle -> flags=4'b1010.
- Stack fill/drain, DEPTH=4: push four distinct values, changing flags between pushes -> full=1. Fifth push -> err=1, depth stays 4. Four pops restore the values in reverse order -> empty=1. Fifth pop -> flags unchanged, err stays 1. err_clr -> err=0.
- Push/pop swap at depth 1, top=4'b0011, flags=4'b1100 -> flags=4'b0011, top=4'b1100, depth=1.
- Condition sweep: for flags in {0000, 0001, 0010, 0100, 1000, 1100, 1010}, check all 16 conds. Example: flags=4'b1000 (N=1, V=0) -> LT=1, GE=0, GT=0, LE=1.
- Async reset mid-sequence: depth=2, flags=4'b1111; assert reset between edges -> flags=0, depth=0, empty=1 immediately, before the next edge.
